prco_core_ctrl: RTL and testbench
=================================

# prco_core_ctrl

Parametrised multi-cycle control unit for the next-generation prco core. It owns the program counter and instruction register, sequences FETCH/DECODE/EXEC/MEM/WB, and drives the external decoder, register file, ALU and a single shared memory port. The memory port uses a req/ack handshake, so variable-latency memories are supported. It replaces the hard-wired chip-enable daisy-chain with one explicit state machine.

## Interface
Parameters:
- DATA_W, 16, instruction/data word width
- ADDR_W, 16, memory address and PC width
- RESET_VEC, 0, PC value after reset (ADDR_W bits)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_en  in  1  run enable; sampled only when a new fetch is about to start
- q_mem_req  out  1  memory request, held until acknowledged
- q_mem_we  out  1  write strobe, qualified by q_mem_req
- q_mem_addr  out  ADDR_W  memory address
- q_mem_wdata  out  DATA_W  store data
- i_mem_ack  in  1  request accepted/completed; may assert in the same cycle as q_mem_req
- i_mem_rdata  in  DATA_W  read data, valid when i_mem_ack=1
- q_instr  out  DATA_W  instruction register, feeds decoder
- i_dec_mem, i_dec_mem_we, i_dec_reg_we, i_dec_halt  in  1 each  decoder flags for q_instr (memory access / store / register write / halt)
- i_st_data  in  DATA_W  store data from register file
- q_alu_ce  out  1  one-cycle ALU enable in EXEC
- i_alu_result  in  DATA_W  ALU result (combinational during EXEC)
- i_alu_branch  in  1  branch taken, valid during EXEC
- q_reg_we  out  1  register write pulse
- q_reg_wdata  out  DATA_W  register write data
- q_pc  out  ADDR_W  current PC
- q_retire  out  1  one-cycle pulse per completed instruction
- q_halted  out  1  high while in HALT
- q_state  out  3  state encoding for debug

## Operation
- States (encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: if i_en=1 -> FETCH, else stay. No request is issued.
- FETCH: q_mem_req=1, q_mem_we=0, q_mem_addr=q_pc. On i_mem_ack: q_instr<=i_mem_rdata -> DECODE.
- DECODE: one cycle. Decoder and register-file outputs settle -> EXEC.
- EXEC: q_alu_ce=1. Latch r_result<=i_alu_result and r_branch<=i_alu_branch. If i_dec_mem -> MEM, else -> WB.
- MEM: q_mem_req=1, q_mem_addr=r_result[ADDR_W-1:0], q_mem_we=i_dec_mem_we, q_mem_wdata=i_st_data. On ack: if load, r_load<=i_mem_rdata -> WB.
- WB:
  - q_reg_we=i_dec_reg_we; q_reg_wdata = r_load for loads (i_dec_mem & ~i_dec_mem_we), else r_result.
  - PC: r_branch ? r_result[ADDR_W-1:0] : q_pc+1, modulo 2^ADDR_W (0xFFFF+1 -> 0x0000 at ADDR_W=16).
  - q_retire=1.
  - Next state: i_dec_halt -> HALT; else i_en -> FETCH; else IDLE.
- HALT: terminal. q_halted=1, no requests. Leaves only on reset.
- i_en=0 never aborts an in-flight instruction. It only blocks the next fetch.
- Address, we and wdata on the memory port stay stable while q_mem_req=1 and ack is low.

## Timing
- Reset (async assert, sync release): state=IDLE, q_pc=RESET_VEC, q_instr=0, all strobes (q_mem_req, q_mem_we, q_alu_ce, q_reg_we, q_retire, q_halted)=0, q_mem_addr/q_mem_wdata/q_reg_wdata=0.
- Reset mid-transaction drops q_mem_req immediately (asynchronously). The pending access is abandoned.
- q_mem_req and q_mem_we decode combinationally from state, so they deassert the cycle after the ack edge.
- Latency with zero-wait memory (ack in the same cycle as req): non-memory instruction = 4 cycles (FETCH, DECODE, EXEC, WB); load/store = 5 cycles. Each extra wait cycle adds 1.
- q_retire, q_reg_we and the PC update all take effect on the WB exit edge.
- A branch target becomes visible on q_mem_addr in the first FETCH cycle after WB.

## Configuration
- PRCO_CTRL_PERF_EN defined:
  - Adds outputs q_perf_cycles and q_perf_retired, 32 bits each.
  - Both reset to 0.
  - cycles increments every clock in any state except IDLE/HALT; retired increments on q_retire.
  - Both wrap at 2^32.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset with RESET_VEC=0x0010, i_en=1, zero-wait memory, 3 ALU instrs -> fetch addrs 0x10, 0x11, 0x12; q_retire every 4 cycles; q_pc=0x13 after third WB.
- Load with i_alu_result=0x0200 and memory returning 0xBEEF after 2 wait cycles -> MEM lasts 3 cycles, addr 0x0200 held stable, q_reg_wdata=0xBEEF with q_reg_we=1, total latency 7 cycles.
- Branch at PC 0x0005, i_alu_branch=1, result 0x0040 -> next fetch addr 0x0040; without branch at PC 0xFFFF -> next fetch addr 0x0000.
- i_en dropped during a MEM wait -> instruction completes and retires, FSM goes to IDLE; i_en=1 -> fetch resumes at PC+1.
- i_reset_n asserted while q_mem_req=1 in FETCH -> q_mem_req=0 in the same cycle, q_pc=RESET_VEC, state=0.
- i_dec_halt on instruction 2 -> q_halted=1, no further q_mem_req for 20 cycles; with PRCO_CTRL_PERF_EN, q_perf_retired=2 and q_perf_cycles=8.

Source files
------------

// File: rtl/prco_core_ctrl.sv
// -----------------------------------------------------------------------------
// prco_core_ctrl
//
// Multi-cycle control unit for the prco core. Owns the program counter and the
// instruction register and walks every instruction through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB over a single shared memory port that
// uses a req/ack handshake, so memories of any latency can be attached.
//
// Optional feature:
//   `define PRCO_CTRL_PERF_EN  adds two free-running 32-bit performance
//   counters (q_perf_cycles, q_perf_retired). Without the macro those ports
//   and counters do not exist and the behaviour is otherwise identical.
//
// Reset is asynchronous assert / synchronous release (active-low i_reset_n).
// The memory strobes are decoded combinationally from the state register, so
// asserting reset drops q_mem_req in the same cycle and abandons any pending
// access.
// -----------------------------------------------------------------------------
module prco_core_ctrl #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en,

    // shared memory port
    output logic              q_mem_req,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [DATA_W-1:0] q_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,

    // decoder
    output logic [DATA_W-1:0] q_instr,
    input  logic              i_dec_mem,
    input  logic              i_dec_mem_we,
    input  logic              i_dec_reg_we,
    input  logic              i_dec_halt,

    // register file / ALU
    input  logic [DATA_W-1:0] i_st_data,
    output logic              q_alu_ce,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_branch,
    output logic              q_reg_we,
    output logic [DATA_W-1:0] q_reg_wdata,

    // status / debug
    output logic [ADDR_W-1:0] q_pc,
    output logic              q_retire,
    output logic              q_halted,
`ifdef PRCO_CTRL_PERF_EN
    output logic [31:0]       q_perf_cycles,
    output logic [31:0]       q_perf_retired,
`endif
    output logic [2:0]        q_state
);

    // -------------------------------------------------------------------------
    // State encoding (visible on q_state for debug, so values are fixed)
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Architectural and pipeline-internal registers
    // -------------------------------------------------------------------------
    logic [2:0]        state_q,  state_d;
    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic [DATA_W-1:0] instr_q,  instr_d;
    logic [DATA_W-1:0] result_q, result_d;   // ALU result captured in EXEC
    logic              branch_q, branch_d;   // branch decision captured in EXEC
    logic [DATA_W-1:0] load_q,   load_d;     // load data captured in MEM

    // ALU result viewed as an address (truncated or zero-extended to ADDR_W)
    logic [ADDR_W-1:0] result_addr;

    // Decoder says this is a load: memory access without write strobe
    logic              is_load;

    // Combinational output strobes
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              alu_ce;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              retire;
    logic              halted;

    assign is_load = i_dec_mem & ~i_dec_mem_we;

    // The result register may be wider or narrower than an address; pick the
    // matching conversion once here so the rest of the logic is width-agnostic.
    generate
        if (ADDR_W <= DATA_W) begin : g_addr_trunc
            assign result_addr = result_q[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign result_addr = {{(ADDR_W-DATA_W){1'b0}}, result_q};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state and datapath register updates
    // -------------------------------------------------------------------------
    // Sequencer: computes the next state and which internal register captures.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        result_d = result_q;
        branch_d = branch_q;
        load_d   = load_q;

        case (state_q)
            ST_IDLE: begin
                // Run enable only matters when a new fetch could begin.
                if (i_en) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Hold the request until the memory accepts it.
                if (i_mem_ack) begin
                    instr_d = i_mem_rdata;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // One cycle for decoder and register file outputs to settle.
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                result_d = i_alu_result;
                branch_d = i_alu_branch;
                state_d  = i_dec_mem ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                if (i_mem_ack) begin
                    if (is_load) begin
                        load_d = i_mem_rdata;
                    end
                    state_d = ST_WB;
                end
            end

            ST_WB: begin
                // PC wraps naturally at 2^ADDR_W.
                pc_d = branch_q ? result_addr : (pc_q + PC_STEP);
                if (i_dec_halt) begin
                    state_d = ST_HALT;
                end else if (i_en) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HALT: begin
                // Terminal until reset.
                state_d = ST_HALT;
            end

            default: begin
                // Unused encoding: recover to a safe, quiet state.
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_VEC;
            instr_q  <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
            load_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            branch_q <= branch_d;
            load_q   <= load_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    // Strobes and port values decoded purely from the current state; the
    // address and write data follow registered/held sources, so they stay
    // stable for as long as a request waits for its ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        alu_ce    = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        retire    = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end

            ST_EXEC: begin
                alu_ce = 1'b1;
            end

            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = i_dec_mem_we;
                mem_addr  = result_addr;
                mem_wdata = i_st_data;
            end

            ST_WB: begin
                reg_we    = i_dec_reg_we;
                reg_wdata = is_load ? load_q : result_q;
                retire    = 1'b1;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                // IDLE, DECODE and unused encodings drive nothing.
            end
        endcase
    end

    assign q_mem_req   = mem_req;
    assign q_mem_we    = mem_we;
    assign q_mem_addr  = mem_addr;
    assign q_mem_wdata = mem_wdata;
    assign q_alu_ce    = alu_ce;
    assign q_reg_we    = reg_we;
    assign q_reg_wdata = reg_wdata;
    assign q_retire    = retire;
    assign q_halted    = halted;
    assign q_instr     = instr_q;
    assign q_pc        = pc_q;
    assign q_state     = state_q;

`ifdef PRCO_CTRL_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    logic [31:0] perf_cycles_q,  perf_cycles_d;
    logic [31:0] perf_retired_q, perf_retired_d;
    logic        core_busy;

    assign core_busy = (state_q != ST_IDLE) && (state_q != ST_HALT);

    // Busy cycles and retired instructions; both wrap at 2^32.
    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_retired_d = perf_retired_q;
        if (core_busy) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
        if (retire) begin
            perf_retired_d = perf_retired_q + 32'd1;
        end
    end

    // Counter registers, asynchronously reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_cycles_q  <= '0;
            perf_retired_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
        end
    end

    assign q_perf_cycles  = perf_cycles_q;
    assign q_perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_prco_core_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prco_core_ctrl
//
// Directed bench for prco_core_ctrl. The bench plays memory, decoder, register
// file and ALU. For every instruction it pushes the expected fetch address and
// expected write-back data into queues and pops them when the DUT shows the
// corresponding fetch request / WB cycle. Inputs are driven just after the
// falling edge and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_prco_core_ctrl;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 16;
    localparam logic [15:0] RVEC   = 16'h0010;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b1;
    logic              i_en = 1'b0;
    logic              q_mem_req;
    logic              q_mem_we;
    logic [ADDR_W-1:0] q_mem_addr;
    logic [DATA_W-1:0] q_mem_wdata;
    logic              i_mem_ack = 1'b0;
    logic [DATA_W-1:0] i_mem_rdata = '0;
    logic [DATA_W-1:0] q_instr;
    logic              i_dec_mem = 1'b0;
    logic              i_dec_mem_we = 1'b0;
    logic              i_dec_reg_we = 1'b0;
    logic              i_dec_halt = 1'b0;
    logic [DATA_W-1:0] i_st_data = '0;
    logic              q_alu_ce;
    logic [DATA_W-1:0] i_alu_result = '0;
    logic              i_alu_branch = 1'b0;
    logic              q_reg_we;
    logic [DATA_W-1:0] q_reg_wdata;
    logic [ADDR_W-1:0] q_pc;
    logic              q_retire;
    logic              q_halted;
`ifdef PRCO_CTRL_PERF_EN
    logic [31:0]       q_perf_cycles;
    logic [31:0]       q_perf_retired;
`endif
    logic [2:0]        q_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_pc;
    logic [15:0] fetch_exp[$];
    logic [15:0] wb_exp[$];

    prco_core_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RVEC)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_en           (i_en),
        .q_mem_req      (q_mem_req),
        .q_mem_we       (q_mem_we),
        .q_mem_addr     (q_mem_addr),
        .q_mem_wdata    (q_mem_wdata),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata),
        .q_instr        (q_instr),
        .i_dec_mem      (i_dec_mem),
        .i_dec_mem_we   (i_dec_mem_we),
        .i_dec_reg_we   (i_dec_reg_we),
        .i_dec_halt     (i_dec_halt),
        .i_st_data      (i_st_data),
        .q_alu_ce       (q_alu_ce),
        .i_alu_result   (i_alu_result),
        .i_alu_branch   (i_alu_branch),
        .q_reg_we       (q_reg_we),
        .q_reg_wdata    (q_reg_wdata),
        .q_pc           (q_pc),
        .q_retire       (q_retire),
        .q_halted       (q_halted),
`ifdef PRCO_CTRL_PERF_EN
        .q_perf_cycles  (q_perf_cycles),
        .q_perf_retired (q_perf_retired),
`endif
        .q_state        (q_state)
    );

    always #5 i_clk = ~i_clk;

    // One comparison: counts, and reports on mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge at which the DUT is in FETCH (bounded).
    task automatic wait_fetch(input string name);
        int k;
        k = 0;
        @(negedge i_clk);
        while (q_state != S_FETCH && k < 10) begin
            @(negedge i_clk);
            k++;
        end
        check({name, ".reach_fetch"}, {29'd0, q_state}, {29'd0, S_FETCH});
    endtask

    // Run one complete instruction, acting as memory/decoder/ALU, checking
    // each stage and the total latency. Caller must be between posedge and
    // negedge; on return the DUT has just left WB (posedge + 1).
    task automatic do_instr(input string name, input bit is_mem, input bit is_we,
                            input bit reg_we, input bit halt, input bit br,
                            input logic [15:0] alu_res, input logic [15:0] mem_data,
                            input logic [15:0] st_data, input int fwait,
                            input int mwait, input bit drop_en);
        logic [15:0] iword;
        int          cyc;
        int          fw;
        int          mw;
        bit          done;
        iword = 16'hC000 ^ model_pc;
        cyc   = 0;
        fw    = 0;
        mw    = 0;
        done  = 1'b0;
        fetch_exp.push_back(model_pc);
        wb_exp.push_back((is_mem && !is_we) ? mem_data : alu_res);
        i_dec_mem    = is_mem;
        i_dec_mem_we = is_we;
        i_dec_reg_we = reg_we;
        i_dec_halt   = halt;
        i_alu_result = alu_res;
        i_alu_branch = br;
        i_st_data    = st_data;
        wait_fetch(name);
        while (!done && cyc < 40) begin
            cyc++;
            case (q_state)
                S_FETCH: begin
                    i_mem_ack   = (fw == fwait);
                    i_mem_rdata = (fw == fwait) ? iword : 16'h5A5A;
                    #1;
                    check({name, ".fetch_req"}, {31'd0, q_mem_req}, 32'd1);
                    check({name, ".fetch_we"}, {31'd0, q_mem_we}, 32'd0);
                    if (fw == 0) begin
                        check({name, ".fetch_addr"}, {16'd0, q_mem_addr}, {16'd0, fetch_exp.pop_front()});
                    end else begin
                        check({name, ".fetch_addr_hold"}, {16'd0, q_mem_addr}, {16'd0, model_pc});
                    end
                    fw++;
                end
                S_DECODE: begin
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = 16'h5A5A;
                    #1;
                    check({name, ".instr"}, {16'd0, q_instr}, {16'd0, iword});
                    check({name, ".decode_req"}, {31'd0, q_mem_req}, 32'd0);
                end
                S_EXEC: begin
                    #1;
                    check({name, ".alu_ce"}, {31'd0, q_alu_ce}, 32'd1);
                end
                S_MEM: begin
                    if (drop_en) i_en = 1'b0;
                    i_mem_ack   = (mw == mwait);
                    i_mem_rdata = (mw == mwait) ? mem_data : 16'h5A5A;
                    #1;
                    check({name, ".mem_req"}, {31'd0, q_mem_req}, 32'd1);
                    check({name, ".mem_we"}, {31'd0, q_mem_we}, {31'd0, is_we});
                    check({name, ".mem_addr"}, {16'd0, q_mem_addr}, {16'd0, alu_res});
                    if (is_we) begin
                        check({name, ".mem_wdata"}, {16'd0, q_mem_wdata}, {16'd0, st_data});
                    end
                    mw++;
                end
                S_WB: begin
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = 16'h5A5A;
                    #1;
                    check({name, ".retire"}, {31'd0, q_retire}, 32'd1);
                    check({name, ".reg_we"}, {31'd0, q_reg_we}, {31'd0, reg_we});
                    check({name, ".reg_wdata"}, {16'd0, q_reg_wdata}, {16'd0, wb_exp.pop_front()});
                    check({name, ".wb_alu_ce"}, {31'd0, q_alu_ce}, 32'd0);
                    done = 1'b1;
                end
                default: begin
                    #1;
                    check({name, ".bad_state"}, {29'd0, q_state}, {29'd0, S_WB});
                    cyc = 40;
                end
            endcase
            if (!done) @(negedge i_clk);
        end
        check({name, ".completed"}, {31'd0, done}, 32'd1);
        check({name, ".latency"}, cyc, 4 + fwait + (is_mem ? 1 + mwait : 0));
        model_pc = br ? alu_res : model_pc + 16'd1;
        @(posedge i_clk);
        #1;
        check({name, ".pc"}, {16'd0, q_pc}, {16'd0, model_pc});
        check({name, ".retire_pulse"}, {31'd0, q_retire}, 32'd0);
        $display("instr %s: %0d cycles, next pc 0x%04h", name, cyc, model_pc);
    endtask

    initial begin
        int req_seen;
        model_pc = RVEC;

        // ---- asynchronous reset values ----
        #1 i_reset_n = 1'b0;
        #2;
        check("rst.state", {29'd0, q_state}, {29'd0, S_IDLE});
        check("rst.pc", {16'd0, q_pc}, {16'd0, RVEC});
        check("rst.instr", {16'd0, q_instr}, 32'd0);
        check("rst.strobes", {26'd0, q_mem_req, q_mem_we, q_alu_ce, q_reg_we, q_retire, q_halted}, 32'd0);
        check("rst.mem_addr", {16'd0, q_mem_addr}, 32'd0);
        check("rst.mem_wdata", {16'd0, q_mem_wdata}, 32'd0);
        check("rst.reg_wdata", {16'd0, q_reg_wdata}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

        // ---- IDLE holds without enable ----
        repeat (3) @(negedge i_clk);
        #1;
        check("idle.state", {29'd0, q_state}, {29'd0, S_IDLE});
        check("idle.req", {31'd0, q_mem_req}, 32'd0);
        i_en = 1'b1;
        @(posedge i_clk);
        #1;

        // ---- three ALU instructions from RESET_VEC ----
        do_instr("alu0", 0, 0, 1, 0, 0, 16'h1111, 16'h0, 16'h0, 0, 0, 0);
        do_instr("alu1", 0, 0, 1, 0, 0, 16'h2222, 16'h0, 16'h0, 0, 0, 0);
        do_instr("alu2", 0, 0, 1, 0, 0, 16'h3333, 16'h0, 16'h0, 0, 0, 0);
        check("alu.pc_after3", {16'd0, q_pc}, 32'h0013);

        // ---- load with two wait cycles, store with a slow fetch ----
        do_instr("load", 1, 0, 1, 0, 0, 16'h0200, 16'hBEEF, 16'h0000, 0, 2, 0);
        do_instr("store", 1, 1, 0, 0, 0, 16'h0300, 16'h0000, 16'h1234, 1, 0, 0);

        // ---- branches and PC wrap ----
        do_instr("br_to5", 0, 0, 0, 0, 1, 16'h0005, 16'h0, 16'h0, 0, 0, 0);
        do_instr("br_at5", 0, 0, 0, 0, 1, 16'h0040, 16'h0, 16'h0, 0, 0, 0);
        do_instr("br_top", 0, 0, 0, 0, 1, 16'hFFFF, 16'h0, 16'h0, 0, 0, 0);
        do_instr("wrap", 0, 0, 1, 0, 0, 16'h4444, 16'h0, 16'h0, 0, 0, 0);
        check("wrap.pc_zero", {16'd0, q_pc}, 32'h0000);

        // ---- enable dropped during a MEM wait ----
        do_instr("drop_en", 1, 0, 1, 0, 0, 16'h0777, 16'hCAFE, 16'h0, 0, 2, 1);
        check("drop_en.idle", {29'd0, q_state}, {29'd0, S_IDLE});
        repeat (3) @(negedge i_clk);
        #1;
        check("drop_en.still_idle", {29'd0, q_state}, {29'd0, S_IDLE});
        check("drop_en.no_req", {31'd0, q_mem_req}, 32'd0);
        i_en = 1'b1;
        @(posedge i_clk);
        #1;
        do_instr("resume", 0, 0, 1, 0, 0, 16'h5555, 16'h0, 16'h0, 0, 0, 0);

        // ---- reset while a fetch is pending ----
        wait_fetch("rst_mid");
        i_mem_ack = 1'b0;
        #1;
        check("rst_mid.req_before", {31'd0, q_mem_req}, 32'd1);
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_mid.req", {31'd0, q_mem_req}, 32'd0);
        check("rst_mid.pc", {16'd0, q_pc}, {16'd0, RVEC});
        check("rst_mid.state", {29'd0, q_state}, {29'd0, S_IDLE});
        @(negedge i_clk);
        i_reset_n = 1'b1;
        model_pc = RVEC;
        @(posedge i_clk);
        #1;

        // ---- halt on the second instruction ----
        do_instr("pre_halt", 0, 0, 1, 0, 0, 16'h0101, 16'h0, 16'h0, 0, 0, 0);
        do_instr("halt", 0, 0, 1, 1, 0, 16'h0202, 16'h0, 16'h0, 0, 0, 0);
        check("halt.state", {29'd0, q_state}, {29'd0, S_HALT});
        check("halt.halted", {31'd0, q_halted}, 32'd1);
        i_dec_halt = 1'b0;
        req_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (q_mem_req) req_seen++;
        end
        check("halt.no_req_20", req_seen, 0);
        check("halt.still_halted", {31'd0, q_halted}, 32'd1);
`ifdef PRCO_CTRL_PERF_EN
        check("perf.retired", q_perf_retired, 32'd2);
        check("perf.cycles", q_perf_cycles, 32'd8);
`endif
        check("queues.empty", fetch_exp.size() + wb_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
